// File: rtl/load_store_unit_if.sv
// Request/response bus between the execute stage and the load/store unit.
// Handshake: a request transfers on a rising edge where req_valid && req_ready; resp_valid is a one-cycle pulse with no backpressure.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: converts byte-addressed requests into word-addressed
// memory strobes with byte enables, and extends load data back to 32 bits.
module load_store_unit #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    load_store_unit_if.slave  bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ld,
    output logic              mem_str,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [2:0]        dbg_state
);
    typedef enum logic [2:0] {IDLE, ACCESS, LWAIT, RESP, ERR} state_t;

    state_t             state_q, state_d;
    logic               we_q, we_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [1:0]         off_q, off_d;
    logic               resp_valid_q, resp_valid_d;
    logic               resp_err_q, resp_err_d;
    logic [31:0]        resp_rdata_q, resp_rdata_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic               mem_ld_q, mem_ld_d;
    logic               mem_str_q, mem_str_d;
    logic [3:0]         mem_be_q, mem_be_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;

    logic        accept;
    logic        req_bad;
    logic [1:0]  req_off;
    logic [31:0] shifted_b, shifted_h, load_data;
    logic        unused_addr;

    assign req_off     = bus.req_addr[1:0];
    assign accept      = bus.req_valid && bus.req_ready;
    assign unused_addr = ^bus.req_addr[31:ADDR_W+2];

    // Illegal funct3 or misaligned halfword/word accesses never reach memory.
    always_comb begin
        req_bad = 1'b0;
        case (bus.req_funct3)
            3'b000:  req_bad = 1'b0;
            3'b001:  req_bad = req_off[0];
            3'b010:  req_bad = |req_off;
            3'b100:  req_bad = bus.req_we;
            3'b101:  req_bad = bus.req_we | req_off[0];
            default: req_bad = 1'b1;
        endcase
    end

    assign shifted_b = mem_rdata >> {off_q, 3'b000};
    assign shifted_h = mem_rdata >> {off_q[1], 4'b0000};

    always_comb begin
        load_data = mem_rdata;
        case (funct3_q)
            3'b000:  load_data = {{24{shifted_b[7]}}, shifted_b[7:0]};
            3'b001:  load_data = {{16{shifted_h[15]}}, shifted_h[15:0]};
            3'b100:  load_data = {24'd0, shifted_b[7:0]};
            3'b101:  load_data = {16'd0, shifted_h[15:0]};
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;
        mem_addr_d   = mem_addr_q;
        mem_ld_d     = 1'b0;
        mem_str_d    = 1'b0;
        mem_be_d     = 4'b0000;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d     = bus.req_we;
                    funct3_d = bus.req_funct3;
                    off_d    = req_off;
                    if (req_bad) begin
                        state_d      = ERR;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'd0;
                    end else begin
                        state_d    = ACCESS;
                        mem_addr_d = bus.req_addr[ADDR_W+1:2];
                        if (bus.req_we) begin
                            mem_str_d = 1'b1;
                            case (bus.req_funct3[1:0])
                                2'b00: begin
                                    mem_be_d    = 4'b0001 << req_off;
                                    mem_wdata_d = {4{bus.req_wdata[7:0]}};
                                end
                                2'b01: begin
                                    mem_be_d    = req_off[1] ? 4'b1100 : 4'b0011;
                                    mem_wdata_d = {2{bus.req_wdata[15:0]}};
                                end
                                default: begin
                                    mem_be_d    = 4'b1111;
                                    mem_wdata_d = bus.req_wdata;
                                end
                            endcase
                        end else begin
                            mem_ld_d = 1'b1;
                        end
                    end
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = 32'd0;
                end else begin
                    state_d = LWAIT;
                end
            end
            LWAIT: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = load_data;
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            funct3_q     <= 3'd0;
            off_q        <= 2'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            mem_addr_q   <= '0;
            mem_ld_q     <= 1'b0;
            mem_str_q    <= 1'b0;
            mem_be_q     <= 4'b0000;
            mem_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_ld_q     <= mem_ld_d;
            mem_str_q    <= mem_str_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE) && !rst;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign mem_addr       = mem_addr_q;
    assign mem_ld         = mem_ld_q;
    assign mem_str        = mem_str_q;
    assign mem_be         = mem_be_q;
    assign mem_wdata      = mem_wdata_q;
    assign dbg_state      = state_q;
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the RV32I execute stage and the word-addressed data memory.
- Accepts one load/store request at a time, carrying a byte address and funct3. Converts it to a word address, a byte-enable mask and lane-replicated write data.
- Drives the memory's ld/str strobes, then extracts and sign- or zero-extends the load result.
- Rejects misaligned or illegal accesses without touching memory.

Parameters:
- ADDR_W, 12, word-address width of the data memory. The memory holds 2**ADDR_W 32-bit words.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit idle and able to accept
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 for the load/store
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or illegal request, qualified by resp_valid
- mem_addr  out  ADDR_W  word address to memory
- mem_ld  out  1  load strobe, one cycle
- mem_str  out  1  store strobe, one cycle
- mem_be  out  4  byte enables, bit i = byte lane i
- mem_wdata  out  32  lane-aligned store data
- mem_rdata  in  32  memory read data, registered in memory, valid the cycle after mem_ld

Behaviour:
- Reset state:
  - On a clk edge with rst=1: state <= IDLE.
  - resp_valid, resp_err, resp_rdata, mem_ld, mem_str, mem_be, mem_wdata and mem_addr all <= 0.
  - req_ready = (state==IDLE) && !rst, so it is 0 during reset.
- Reset mid-operation: any in-flight request is abandoned. No response is produced, and strobes are low from the next cycle.
- Accept: the handshake fires when req_valid && req_ready. All request fields are registered at that edge.
- Word address and byte offset: mem_addr = req_addr[ADDR_W+1:2]. Bits above ADDR_W+1 are ignored (address wraps). off = req_addr[1:0].
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Error conditions:
  - Illegal funct3.
  - Halfword access with off[0]=1.
  - Word access with off!=0.
- FSM states: IDLE, ACCESS, LWAIT, RESP, ERR.
- IDLE:
  - Accept of an erroring request -> ERR.
  - Any other accept -> ACCESS.
- ERR:
  - resp_valid=1, resp_err=1, resp_rdata=0.
  - mem_ld=mem_str=0; memory is never accessed.
  - Next state -> IDLE.
- ACCESS (one cycle): registered outputs are presented.
  - mem_addr is driven as above.
  - A load drives mem_ld=1 and mem_be=0000.
  - SB drives mem_str=1, mem_be=0001<<off, mem_wdata={4{wdata[7:0]}}.
  - SH drives mem_str=1, mem_be = off[1] ? 1100 : 0011, mem_wdata={2{wdata[15:0]}}.
  - SW drives mem_str=1, mem_be=1111, mem_wdata=wdata.
  - Next state: load -> LWAIT, store -> RESP.
- LWAIT:
  - Strobes low.
  - Lane is selected from mem_rdata: byte = mem_rdata >> (8*off); half = mem_rdata >> (16*off[1]).
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
  - The result is registered into resp_rdata. Next state -> RESP.
- RESP:
  - resp_valid=1, resp_err=0.
  - resp_rdata holds load data for loads and 0 for stores.
  - Next state -> IDLE.
- Pulse rules:
  - resp_valid is a single-cycle pulse with no backpressure.
  - resp_rdata holds its value until the next response.
  - mem_ld and mem_str are never high together and are each high for exactly one cycle per legal access.
- Latency, measured from the accept edge to resp_valid high:
  - Error: 1 cycle.
  - Store: 2 cycles.
  - Load: 3 cycles.
  - The next accept is possible on the cycle after resp_valid.
- req_valid while busy is ignored: req_ready=0, so nothing is captured.

Test Plan:
- SW addr=0x0000_0008, wdata=0xDEADBEEF -> ACCESS cycle: mem_addr=2, mem_str=1, mem_be=1111, mem_wdata=0xDEADBEEF. resp_valid 2 cycles after accept, resp_err=0.
- SB addr=0x0000_0006, wdata=0x000000A5 -> mem_addr=1, mem_be=0100, mem_wdata=0xA5A5A5A5, single-cycle mem_str.
- With memory word 1 = 0x80F1_7F22:
  - LB addr=0x5 -> resp_rdata=0x0000007F.
  - LB addr=0x6 -> 0xFFFFFFF1.
  - LBU addr=0x7 -> 0x00000080.
  - LH addr=0x6 -> 0xFFFF80F1.
  - LHU addr=0x4 -> 0x00007F22.
  - Each with resp_valid exactly 3 cycles after accept.
- Error cases:
  - LW addr=0x2 -> resp_valid+resp_err 1 cycle after accept, resp_rdata=0, mem_ld/mem_str never asserted.
  - SH addr=0x3 -> same error response.
  - Store funct3=100 -> same error response.
- Back-to-back loads with req_valid held high -> req_ready low for 3 cycles after each accept. The second request is accepted the cycle after the first resp_valid, and its fields are unaffected by req changes while busy.
- Assert rst in the LWAIT cycle of a load -> no resp_valid. All outputs 0 after that edge, req_ready=1 the cycle after rst drops, and a following SW completes normally.
